// File: rtl/uart_tx_baud.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_baud
// Purpose  : UART transmitter with a built-in programmable baud-tick timer
//            (16x oversampling) and an LSB-first serial framing FSM.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit follows the data bits
//   undefined -> plain start / DBIT data / stop framing
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   tx_start     in   one-cycle request to send tx_din (honoured in idle only)
//   tx_din       in   data byte, captured when the request is accepted
//   final_value  in   timer terminal count; tick period = final_value+1 clks
//   s_tick       out  baud tick, one clk wide
//   tx           out  serial line (registered, idle high)
//   tx_reg       out  the tx register itself
//   tx_done_tick out  one-clk pulse on the last stop-bit tick
//   state_out    out  FSM state: idle=00 start=01 data=10 stop=11
//   s_reg        out  oversampling tick counter
//   b_next       out  next-state value of the data shift register
// ============================================================================
module uart_tx_baud #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int BITS    = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  input  logic [BITS-1:0] final_value,
  output logic            s_tick,
  output logic            tx,
  output logic            tx_reg,
  output logic            tx_done_tick,
  output logic [1:0]      state_out,
  output logic [3:0]      s_reg,
  output logic [DBIT-1:0] b_next
);

  // The tick counter must reach SB_TICK-1 in the stop state, which can exceed
  // the 4-bit range used for start/data bits (e.g. 2 stop bits = 32 ticks).
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

`ifdef UART_TX_PARITY_EN
  localparam int LAST_BIT = DBIT;      // parity rides as one extra data slot
`else
  localparam int LAST_BIT = DBIT - 1;
`endif
  localparam int NW = (LAST_BIT < 1) ? 1 : $clog2(LAST_BIT + 1);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(LAST_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  // --------------------------------------------------------------------------
  // Baud timer: free running, independent of the FSM. Wrapping only on an
  // exact match means a counter already above a lowered terminal count runs
  // up to all-ones and wraps naturally before locking onto the new period.
  // --------------------------------------------------------------------------
  logic [BITS-1:0] q_reg;

  assign s_tick = (q_reg == final_value);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_reg <= '0;
    else          q_reg <= s_tick ? '0 : q_reg + BITS'(1);
  end

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  state_t          state, state_nx;
  logic [SW-1:0]   s_cnt, s_nx;
  logic [NW-1:0]   n_reg, n_nx;
  logic [DBIT-1:0] b_reg;
  logic            tx_next;
`ifdef UART_TX_PARITY_EN
  logic            par_reg, par_nx;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n_reg  <= '0;
      b_reg  <= '0;
      tx_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_reg <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      s_cnt  <= s_nx;
      n_reg  <= n_nx;
      b_reg  <= b_next;
      tx_reg <= tx_next;
`ifdef UART_TX_PARITY_EN
      par_reg <= par_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    s_nx         = s_cnt;
    n_nx         = n_reg;
    b_next       = b_reg;
    tx_next      = 1'b1;
    tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nx       = par_reg;
`endif
    case (state)
      IDLE: begin
        if (tx_start) begin
          state_nx = START;
          s_nx     = '0;
          b_next   = tx_din;
`ifdef UART_TX_PARITY_EN
          par_nx   = ^tx_din;
`endif
        end
      end
      START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (s_cnt == S_BIT_LAST) begin
            state_nx = DATA;
            s_nx     = '0;
            n_nx     = '0;
          end else begin
            s_nx = s_cnt + SW'(1);
          end
        end
      end
      DATA: begin
`ifdef UART_TX_PARITY_EN
        tx_next = (n_reg == N_LAST) ? par_reg : b_reg[0];
`else
        tx_next = b_reg[0];
`endif
        if (s_tick) begin
          if (s_cnt == S_BIT_LAST) begin
            s_nx   = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) state_nx = STOP;
            else                 n_nx     = n_reg + NW'(1);
          end else begin
            s_nx = s_cnt + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == S_STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_nx     = IDLE;
          end else begin
            s_nx = s_cnt + SW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign tx        = tx_reg;
  assign state_out = state;
  assign s_reg     = s_cnt[3:0];

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_baud.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_baud
// Purpose  : Self-checking bench for uart_tx_baud. Expected line, state,
//            tick-counter and done values are computed arithmetically from
//            the tick grid (ticking edges are multiples of T after reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_baud;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int BITS    = 11;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DBIT + 1;
`else
  localparam int NB = DBIT;
`endif
  localparam int KL = 16 + 16 * NB + SB_TICK;   // ticks in a whole frame

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            tx_start = 1'b0;
  logic [DBIT-1:0] tx_din = '0;
  logic [BITS-1:0] final_value = '0;
  logic            s_tick, tx, tx_reg, tx_done_tick;
  logic [1:0]      state_out;
  logic [3:0]      s_reg;
  logic [DBIT-1:0] b_next;

  int tests = 0;
  int fails = 0;
  int cyc;                       // posedges since reset release
  logic [7:0] frame_data [0:3];

  uart_tx_baud #(.DBIT(DBIT), .SB_TICK(SB_TICK), .BITS(BITS)) dut (
    .clk(clk), .reset_n(reset_n), .tx_start(tx_start), .tx_din(tx_din),
    .final_value(final_value), .s_tick(s_tick), .tx(tx), .tx_reg(tx_reg),
    .tx_done_tick(tx_done_tick), .state_out(state_out), .s_reg(s_reg),
    .b_next(b_next)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Tick count since acceptance edge E, observed after edge e (e >= E).
  function automatic int k_of(input int e, input int E, input int T);
    return e / T - E / T;
  endfunction

  function automatic logic [1:0] exp_state(input int e, input int E, input int T);
    int k;
    if (e < E) return 2'b00;
    k = k_of(e, E, T);
    if (k < 16)          return 2'b01;
    if (k < 16 + 16*NB)  return 2'b10;
    if (k < KL)          return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic exp_line(input int e, input int E, input int T,
                                    input logic [NB-1:0] fb);
    int k;
    if (e < E) return 1'b1;
    k = k_of(e, E, T);
    if (k < 16)         return 1'b0;
    if (k < 16 + 16*NB) return fb[(k - 16) / 16];
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_s(input int e, input int E, input int T);
    int k;
    k = k_of(e, E, T);
    if (k < 16)         return 4'(k);
    if (k < 16 + 16*NB) return 4'((k - 16) % 16);
    return 4'((k - 16 - 16*NB) % 16);
  endfunction

  task automatic do_reset(input int fv);
    @(negedge clk);
    tx_start    = 1'b0;
    final_value = BITS'(fv);
    reset_n     = 1'b0;
    #2 reset_n  = 1'b1;
  endtask

  // Drives nf frames from frame_data; returns per-category mismatch counts.
  task automatic run_frames(input int T, input int nf, input int busy_off,
                            input bit chain_junk,
                            output int tx_err, output int st_err,
                            output int s_err, output int dn_err,
                            output int first_bad);
    int E, tl, e;
    logic [NB-1:0] fb;
    logic [1:0] es;
    tx_err = 0; st_err = 0; s_err = 0; dn_err = 0; first_bad = -1;
    @(negedge clk);
    E = cyc + 1;
    for (int f = 0; f < nf; f++) begin
      fb       = frame_bits(frame_data[f]);
      tx_start = 1'b1;
      tx_din   = frame_data[f];
      tl = (E / T + 1) * T + (KL - 1) * T;
      do begin
        @(negedge clk);
        e        = cyc;
        tx_start = 1'b0;
        tx_din   = DBIT'($urandom);
        es = exp_state(e, E, T);
        if (state_out !== es) begin st_err++; if (first_bad < 0) first_bad = e; end
        if (es != 2'b00 && s_reg !== exp_s(e, E, T)) begin
          s_err++; if (first_bad < 0) first_bad = e;
        end
        if (tx !== exp_line(e - 1, E, T, fb)) begin
          tx_err++; if (first_bad < 0) first_bad = e;
        end
        if (tx_done_tick !== (e + 1 == tl)) begin
          dn_err++; if (first_bad < 0) first_bad = e;
        end
        if (busy_off > 0 && e == E + busy_off) begin
          tx_start = 1'b1; tx_din = 8'h55;
        end
        if (chain_junk && f < nf - 1 && e == tl - 1) begin
          tx_start = 1'b1; tx_din = ~frame_data[f + 1];
        end
      end while (e < tl);
      E = tl + 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_n = 1'b0; tx_start = 1'b0; final_value = 11'd3;
    #20;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got=%b exp=1", tx); end
    tests++; if (state_out !== 2'b00) begin fails++; $display("FAIL reset_state got=%b exp=00", state_out); end
    tests++; if (tx_done_tick !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", tx_done_tick); end
    tests++; if (s_reg !== 4'd0) begin fails++; $display("FAIL reset_s_reg got=%0d exp=0", s_reg); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_baud_timer;
    int T, errs, ticks, e, e0, ez, q0;
    logic exp;
    T = 651; errs = 0; ticks = 0;
    do_reset(650);
    repeat (3 * 651 + 5) begin
      @(negedge clk);
      e = cyc;
      exp = (e % T == T - 1);
      if (s_tick !== exp) errs++;
      if (s_tick === 1'b1) ticks++;
    end
    tests++; if (errs !== 0) begin fails++; $display("FAIL baud_tick_phase mismatches=%0d exp=0", errs); end
    tests++; if (ticks !== 3) begin fails++; $display("FAIL baud_tick_count got=%0d exp=3", ticks); end
    // Lower final_value while Q is above it: Q must run to 2047 and wrap.
    q0 = 600;
    while (cyc % T != q0) @(negedge clk);
    e0 = cyc;
    final_value = 11'd10;
    ez = e0 + 2048 - q0;
    errs = 0;
    while (cyc < ez + 40) begin
      e = cyc;
      exp = (e >= ez) && ((e - ez) % 11 == 10);
      if (s_tick !== exp) errs++;
      @(negedge clk);
    end
    tests++; if (errs !== 0) begin fails++; $display("FAIL baud_lowered_fv mismatches=%0d exp=0", errs); end
  endtask

  task automatic test_frame;
    int T, te, se, ce, de, fb_e;
    for (int i = 0; i < 3; i++) begin
      T = (i == 0) ? 1 : int'($urandom_range(1, 4));
      frame_data[0] = (i == 0) ? 8'hAA : 8'($urandom);
      do_reset(T - 1);
      run_frames(T, 1, 0, 1'b0, te, se, ce, de, fb_e);
      tests++; if (te !== 0) begin fails++; $display("FAIL frame_tx din=%h T=%0d mismatches=%0d exp=0 first_cycle=%0d", frame_data[0], T, te, fb_e); end
      tests++; if (se !== 0) begin fails++; $display("FAIL frame_state din=%h T=%0d mismatches=%0d exp=0", frame_data[0], T, se); end
      tests++; if (ce !== 0) begin fails++; $display("FAIL frame_s_reg din=%h T=%0d mismatches=%0d exp=0", frame_data[0], T, ce); end
      tests++; if (de !== 0) begin fails++; $display("FAIL frame_done din=%h T=%0d mismatches=%0d exp=0", frame_data[0], T, de); end
    end
  endtask

  task automatic test_busy;
    int T, te, se, ce, de, fb_e;
    T = int'($urandom_range(1, 3));
    frame_data[0] = 8'hAA;
    do_reset(T - 1);
    run_frames(T, 1, int'($urandom_range(40, 100)) * T, 1'b0, te, se, ce, de, fb_e);
    tests++; if (te !== 0) begin fails++; $display("FAIL busy_tx mismatches=%0d exp=0 first_cycle=%0d", te, fb_e); end
    tests++; if (se + de !== 0) begin fails++; $display("FAIL busy_state_done mismatches=%0d exp=0", se + de); end
  endtask

  task automatic test_back_to_back;
    int T, te, se, ce, de, fb_e;
    T = int'($urandom_range(1, 2));
    for (int i = 0; i < 3; i++) frame_data[i] = 8'($urandom);
    do_reset(T - 1);
    run_frames(T, 3, 0, 1'b1, te, se, ce, de, fb_e);
    tests++; if (te !== 0) begin fails++; $display("FAIL b2b_tx mismatches=%0d exp=0 first_cycle=%0d", te, fb_e); end
    tests++; if (se !== 0) begin fails++; $display("FAIL b2b_state mismatches=%0d exp=0 first_cycle=%0d", se, fb_e); end
    tests++; if (ce + de !== 0) begin fails++; $display("FAIL b2b_s_done mismatches=%0d exp=0", ce + de); end
  endtask

  task automatic test_reset_mid_frame_and_parity;
    int te, se, ce, de, fb_e;
    do_reset(1);
    @(negedge clk);
    tx_start = 1'b1; tx_din = 8'h00;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (60) @(negedge clk);   // T=2: start bit ends near cycle 32
    tests++; if (tx !== 1'b0 || state_out !== 2'b10) begin fails++; $display("FAIL midframe_pre tx=%b state=%b exp tx=0 state=10", tx, state_out); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midframe_async_tx got=%b exp=1", tx); end
    tests++; if (state_out !== 2'b00 || s_reg !== 4'd0) begin fails++; $display("FAIL midframe_async_state state=%b s=%0d exp 00/0", state_out, s_reg); end
    @(negedge clk); reset_n = 1'b1;
    frame_data[0] = 8'h07;          // parity bit, when enabled, is 1
    do_reset(0);
    run_frames(1, 1, 0, 1'b0, te, se, ce, de, fb_e);
    tests++; if (te + se + ce + de !== 0) begin fails++; $display("FAIL parity_frame mismatches=%0d exp=0 first_cycle=%0d", te + se + ce + de, fb_e); end
  endtask

  initial begin
    test_reset;
    test_baud_timer;
    test_frame;
    test_busy;
    test_back_to_back;
    test_reset_mid_frame_and_parity;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
